// File: rtl/io_trace_capture.sv
// Pin-trace capture buffer: pre-trigger samples are kept in a circular buffer,
// the buffer fills after the trigger, and a drain read empties it once full.
module io_trace_capture #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    parameter int PRE   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_en,
    input  logic                     arm,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         match_val,
    input  logic [WIDTH-1:0]         match_mask,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic [$clog2(DEPTH):0]   count
);

    // state   | meaning
    // IDLE    | samples ignored, waiting for arm
    // ARMED   | rolling pre-trigger window, evaluating trigger
    // CAPTURE | trigger seen, storing until buffer full
    // DONE    | buffer frozen, draining via rd_req
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(PRE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic              triggered_q;
    logic              have_prev_q;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic trig;
    logic wr_en;
    logic drop_oldest;
    logic rd_en;

    always_comb begin
        case (mode)
            2'b01:   trig = have_prev_q && (sample_in != prev_q);
            2'b10:   trig = ((sample_in ^ match_val) & match_mask) == '0;
            default: trig = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        drop_oldest = 1'b0;
        rd_en       = 1'b0;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (sample_en) begin
                        if (trig) begin
                            wr_en   = 1'b1;
                            state_d = (count_q == CNT_LAST) ? S_DONE : S_CAPTURE;
                        end else if (PRE != 0) begin
                            // window full: overwrite in place by sliding both pointers
                            wr_en       = 1'b1;
                            drop_oldest = (count_q == CNT_PRE);
                        end
                    end
                end
                S_CAPTURE: begin
                    if (sample_en) begin
                        wr_en = 1'b1;
                        if (count_q == CNT_LAST) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_req && count_q != '0) begin
                        rd_en = 1'b1;
                        if (count_q == CNT_ONE) state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state     = state_q;
        count     = count_q;
        triggered = triggered_q;
        rd_valid  = rd_valid_q;
        rd_data   = rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else if (arm) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            have_prev_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (drop_oldest || rd_en) rptr_q <= rptr_q + 1'b1;
            if (wr_en && !drop_oldest) count_q <= count_q + 1'b1;
            else if (rd_en)            count_q <= count_q - 1'b1;
            if (rd_en) rd_data_q <= mem_q[rptr_q];
            if (state_q == S_ARMED && sample_en) begin
                prev_q      <= sample_in;
                have_prev_q <= 1'b1;
                if (trig) triggered_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_trace_capture.sv
// Bench for io_trace_capture: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_trace_capture;

    localparam int WIDTH = 24;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  sample_in = '0;
    logic              sample_en = 1'b0;
    logic              arm = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [WIDTH-1:0]  match_val = '0;
    logic [WIDTH-1:0]  match_mask = '0;
    logic              rd_req = 1'b0;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic              triggered;
    logic [4:0]        count;

    io_trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRE(PRE)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en),
        .arm(arm), .mode(mode), .match_val(match_val), .match_mask(match_mask),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .state(state), .triggered(triggered), .count(count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: stored samples as a queue, phase as a small integer
    int               m_state = 0;
    logic [WIDTH-1:0] mq[$];
    logic             m_trig = 1'b0;
    logic             m_have = 1'b0;
    logic [WIDTH-1:0] m_prev = '0;
    logic [WIDTH-1:0] m_rd_data = '0;
    logic             m_rd_valid = 1'b0;
    logic [WIDTH-1:0] got[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fires(logic [1:0] md, logic [WIDTH-1:0] s);
        if (md == 2'b01) return m_have && (s != m_prev);
        if (md == 2'b10) return (s & match_mask) == (match_val & match_mask);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; mq.delete(); m_trig = 0; m_have = 0;
        m_rd_data = '0; m_rd_valid = 0;
    endtask

    task automatic model_step();
        logic t;
        m_rd_valid = 0;
        if (arm) begin
            mq.delete(); m_state = 1; m_trig = 0; m_have = 0;
        end else if (m_state == 1) begin
            if (sample_en) begin
                t = fires(mode, sample_in);
                if (t) begin
                    mq.push_back(sample_in);
                    m_trig = 1;
                    m_state = (mq.size() == DEPTH) ? 3 : 2;
                end else if (PRE > 0) begin
                    mq.push_back(sample_in);
                    if (mq.size() > PRE) void'(mq.pop_front());
                end
                m_have = 1;
                m_prev = sample_in;
            end
        end else if (m_state == 2) begin
            if (sample_en) begin
                mq.push_back(sample_in);
                if (mq.size() == DEPTH) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (rd_req && mq.size() > 0) begin
                m_rd_data = mq.pop_front();
                m_rd_valid = 1;
                if (mq.size() == 0) m_state = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
        #1;
        if (rd_valid) got.push_back(rd_data);
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(mq.size()));
        chk("triggered", 64'(triggered), 64'(m_trig));
        chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    end

    task automatic step(logic a, logic en, logic [WIDTH-1:0] s, logic r);
        arm = a; sample_en = en; sample_in = s; rd_req = r;
        @(negedge clk);
    endtask

    task automatic drain(int n);
        got.delete();
        for (int i = 0; i < n; i++) step(0, 0, '0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(state), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        rst = 0;
        step(0, 1, 24'h55, 1);
        chk("idle_ignores", 64'(count), 0);

        // immediate trigger, 16 entries kept, the rest ignored
        mode = 2'b00;
        step(1, 0, '0, 0);
        for (int i = 1; i <= 20; i++) step(0, 1, WIDTH'(i), 0);
        chk("imm_state", 64'(state), 3);
        chk("imm_trig", 64'(triggered), 1);
        drain(16);
        for (int i = 0; i < 16; i++) chk("imm_rd", 64'(got[i]), 64'(i + 1));
        step(0, 0, '0, 1);
        chk("extra_rd_valid", 64'(rd_valid), 0);
        chk("after_rd_state", 64'(state), 0);
        chk("after_rd_trig", 64'(triggered), 1);

        // masked match: 4 pre-trigger samples + trigger + 11 post
        mode = 2'b10; match_mask = 24'h0000FF; match_val = 24'h000042;
        step(1, 0, '0, 0);
        step(0, 1, 24'd1, 1);
        chk("armed_rd_valid", 64'(rd_valid), 0);
        for (int i = 2; i <= 100; i++) step(0, 1, WIDTH'(i), 0);
        chk("mm_count", 64'(count), 16);
        drain(16);
        for (int i = 0; i < 16; i++) chk("mm_rd", 64'(got[i]), 64'(24'h3E + i));

        // on-change: 4 of the six 5s retained, then 9
        mode = 2'b01;
        step(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 24'd5, 0);
        chk("chg_no_trig", 64'(triggered), 0);
        step(0, 1, 24'd9, 0);
        for (int i = 10; i <= 25; i++) step(0, 1, WIDTH'(i), 0);
        drain(16);
        chk("chg_rd0", 64'(got[0]), 5);
        chk("chg_rd3", 64'(got[3]), 5);
        chk("chg_rd4", 64'(got[4]), 9);
        chk("chg_rd5", 64'(got[5]), 10);

        // abort mid-capture, then a clean capture
        mode = 2'b00;
        step(1, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, WIDTH'(100 + i), 0);
        chk("abort_pre_count", 64'(count), 8);
        chk("abort_pre_state", 64'(state), 2);
        step(1, 1, 24'hFFFF, 0);
        chk("abort_count", 64'(count), 0);
        chk("abort_trig", 64'(triggered), 0);
        chk("abort_state", 64'(state), 1);
        for (int i = 0; i < 16; i++) step(0, 1, WIDTH'(200 + i), 0);
        drain(16);
        for (int i = 0; i < 16; i++) chk("abort_rd", 64'(got[i]), 64'(200 + i));

        // asynchronous reset in the middle of a readout
        step(1, 0, '0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, WIDTH'(300 + i), 0);
        drain(3);
        chk("pre_rst_valid", 64'(rd_valid), 1);
        #2 rst = 1;
        #1;
        chk("async_state", 64'(state), 0);
        chk("async_count", 64'(count), 0);
        chk("async_trig", 64'(triggered), 0);
        chk("async_valid", 64'(rd_valid), 0);
        chk("async_data", 64'(rd_data), 0);
        @(negedge clk);
        rst = 0;
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // randomized traffic against the model
        step(1, 0, '0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic a;
            a = ($urandom_range(0, 99) == 0);
            if (a) begin
                mode = 2'($urandom_range(0, 3));
                match_mask = WIDTH'($urandom_range(0, 7));
                match_val = WIDTH'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1;
                step(0, 0, '0, 0);
                rst = 0;
            end
            step(a, ($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_trace_capture.md
IO_TRACE_CAPTURE -- requirements
Module: io_trace_capture

Interface
REQ-001 Parameter WIDTH, default 24, sample width (uo_out, uio_out, uio_oe concatenated); legal 1..64.
REQ-002 Parameter DEPTH, default 16, buffer entries; power of two, 4..256.
REQ-003 Parameter PRE, default 4, max retained pre-trigger samples; legal 0..DEPTH-1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high; release is synchronised externally.
REQ-006 sample_in  in  WIDTH  observed pin vector.
REQ-007 sample_en  in  1  qualifies sample_in for the current cycle.
REQ-008 arm  in  1  single-cycle pulse starting a new capture.
REQ-009 mode  in  2  trigger mode: 00 immediate, 01 on-change, 10 masked match, 11 treated as 00.
REQ-010 match_val, match_mask  in  WIDTH each  masked-match compare operands.
REQ-011 rd_req  in  1  request for the next stored sample.
REQ-012 rd_data  out  WIDTH  read sample; rd_valid  out  1  rd_data qualifier.
REQ-013 state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
REQ-014 triggered  out  1  high from trigger until the next arm or reset.
REQ-015 count  out  clog2(DEPTH)+1  number of stored, unread samples.

Function
REQ-016 Circular buffer: write pointer, read pointer (oldest entry), count; pointers wrap modulo DEPTH.
REQ-017 IDLE: samples ignored; arm -> ARMED with pointers, count, triggered and change-history flag cleared.
REQ-018 ARMED: each sample_en writes one entry and evaluates the trigger on the same sample.
REQ-019 ARMED with non-triggering sample and count == PRE: oldest entry discarded (read pointer advances); count stays PRE.
REQ-020 PRE = 0: non-triggering samples are not stored.
REQ-021 Immediate trigger: first sample_en after arm.
REQ-022 On-change trigger: sample_in differs from the previous qualified sample since arm; the first sample after arm never triggers.
REQ-023 Masked-match trigger: (sample_in & match_mask) == (match_val & match_mask); an all-zero mask triggers on the first sample.
REQ-024 Triggering sample is always stored; the next cycle has state = CAPTURE and triggered = 1.
REQ-025 CAPTURE: each sample_en stores one entry; the write bringing count to DEPTH -> DONE on the next cycle.
REQ-026 Trigger on a sample that fills the buffer (count becomes DEPTH) -> DONE directly.
REQ-027 DONE: new samples are ignored; buffer contents are frozen.
REQ-028 Read, DONE only: rd_req with count > 0 -> next cycle rd_data = oldest entry, rd_valid = 1 for exactly one cycle; read pointer advances; count decrements.
REQ-029 rd_req outside DONE, or with count == 0: ignored, rd_valid stays 0.
REQ-030 Read that brings count to 0 -> IDLE on the same edge; triggered stays 1.
REQ-031 rd_req held high: one entry per cycle.
REQ-032 rd_data holds its last value when rd_valid = 0.
REQ-033 arm in any state, including mid-capture or mid-readout: abort; re-enter ARMED as in REQ-017; any same-cycle rd_req or sample is discarded.
REQ-034 Samples are emitted strictly in capture order; no entry is duplicated or lost.

Reset
REQ-035 rst high: state = IDLE, count = 0, triggered = 0, rd_valid = 0, rd_data = 0, pointers = 0, immediately and independent of clk.
REQ-036 Buffer storage needs no reset; contents are unobservable until rewritten.
REQ-037 rst mid-capture or mid-readout: all data is lost; no rd_valid until a new capture completes.

Verification
REQ-038 Defaults, mode 00, arm, then samples 1..20 -> DONE after sample 16, triggered = 1, 16 reads return 1..16.
REQ-039 Mode 10, mask 0x0000FF, val 0x000042, samples 1..100 -> stored 0x3E,0x3F,0x40,0x41,0x42..0x4D (4 pre, 12 post), count = 16.
REQ-040 Mode 01, samples 5,5,5,5,5,5,9,... -> trigger at 9, first read returns 5 (four 5s retained), fifth read returns 9.
REQ-041 rd_req in ARMED, and an extra rd_req after count reaches 0 -> no rd_valid; after the last read, state = IDLE.
REQ-042 arm during CAPTURE after 8 entries -> count = 0, triggered = 0, state = ARMED; next full capture reads back correctly.
REQ-043 rst asserted mid-readout between clock edges -> outputs reach their REQ-035 values before the next clock edge.
